// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready register between two pipeline stages, 2-entry skid buffer.
// Latency: 1 cycle from accept to out_* when empty (or when main is drained the same cycle).
// Backpressure: in_ready is a pure register output (low only when both entries are held);
//   flush kills held entries and any same-cycle offer.
// Optional build macro: PIPE_STAT_EN adds the stall_cnt / flush_cnt statistics counters.
module pipe_stage_reg #(
  parameter int                PC_W     = 32,
  parameter int                DATA_W   = 32,
`ifdef PIPE_STAT_EN
  parameter int                CNT_W    = 16,
`endif
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  // upstream side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc4,
  input  logic [DATA_W-1:0] in_data,
  // pipeline control
  input  logic              flush,
`ifdef PIPE_STAT_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  // downstream side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc4,
  output logic [DATA_W-1:0] out_data
);

  // Occupancy state: EMPTY (no entry), BUSY (main only), FULL (main + skid).
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]        r_state;
  logic              r_main_vld;
  logic              r_skid_vld;
  logic [PC_W-1:0]   r_main_pc4;
  logic [DATA_W-1:0] r_main_data;
  logic [PC_W-1:0]   r_skid_pc4;
  logic [DATA_W-1:0] r_skid_data;

  logic [1:0]        w_state_nxt;
  logic              w_accept;
  logic              w_take;
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;

  // in_ready comes straight from the state register, so there is no
  // combinational path from out_ready back to the upstream stage.
  assign in_ready  = (r_state != S_FULL);
  assign out_valid = r_main_vld;
  assign out_pc4   = r_main_pc4;
  assign out_data  = r_main_vld ? r_main_data : NOP_WORD;

  // An offer coinciding with flush is discarded, so it never counts as accepted.
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_take    = r_main_vld & out_ready;

  // Next-state and entry-load decisions; flush overrides every transition.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = S_BUSY;
          w_load_main_in = 1'b1;
        end
      end
      S_BUSY: begin
        if (w_accept && w_take) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_take) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // The skid valid bit guards the refill so a stale skid word can never
        // be promoted into main.
        if (w_take && r_skid_vld) begin
          w_state_nxt      = S_BUSY;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
    if (flush) begin
      w_state_nxt      = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  // State register and the per-entry valid bits that track it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_EMPTY;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_main_vld <= (w_state_nxt != S_EMPTY);
      r_skid_vld <= (w_state_nxt == S_FULL);
    end
  end

  // Main entry payload: loaded from upstream or promoted from skid; otherwise
  // held, so out_pc4 keeps its last value after the entry drains or is flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_pc4  <= '0;
      r_main_data <= NOP_WORD;
    end else if (w_load_main_in) begin
      r_main_pc4  <= in_pc4;
      r_main_data <= in_data;
    end else if (w_load_main_skid) begin
      r_main_pc4  <= r_skid_pc4;
      r_main_data <= r_skid_data;
    end
  end

  // Skid entry payload: captures the offer that arrives while main is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skid_pc4  <= '0;
      r_skid_data <= NOP_WORD;
    end else if (w_load_skid) begin
      r_skid_pc4  <= in_pc4;
      r_skid_data <= in_data;
    end
  end

`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Saturating count of cycles where a valid entry is held by downstream stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (r_main_vld && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Saturating count of flushes that actually killed a held entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_cnt <= '0;
    end else if (flush && (r_main_vld || r_skid_vld) && (r_flush_cnt != {CNT_W{1'b1}})) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vectors, expected entries queued at issue time,
// an independent negedge monitor pops and compares every downstream transfer.
module tb_pipe_stage_reg;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;
`ifdef PIPE_STAT_EN
  localparam int CNT_W  = 4;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc4;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc4;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .PC_W     (PC_W),
    .DATA_W   (DATA_W),
`ifdef PIPE_STAT_EN
    .CNT_W    (CNT_W),
`endif
    .NOP_WORD (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc4    (in_pc4),
    .in_data   (in_data),
    .flush     (flush),
`ifdef PIPE_STAT_EN
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc4   (out_pc4),
    .out_data  (out_data)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] dat, input bit expect_out);
    in_valid = 1'b1;
    in_pc4   = pc;
    in_data  = dat;
    if (expect_out) exp_q.push_back({pc, dat});
  endtask

  // Monitor: every downstream transfer must match the oldest expected entry;
  // an empty stage must present the NOP word.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got pc4=%h data=%h, required no transfer", out_pc4, out_data);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_entry", {out_pc4, out_data}, mon_exp);
        end
      end
      if (!out_valid) check("nop_when_empty", out_data, NOP);
    end
  end

  initial begin
    // Reset with an offer present: nothing may be captured.
    rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_pc4 = 32'h4; in_data = 32'h2008_0005;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, NOP);
    check("rst_out_pc4", out_pc4, 0);
    cyc();
    check("rst_hold_out_valid", out_valid, 0);

    // First transaction after reset release.
    rst = 1'b1;
    offer(32'h4, 32'h2008_0005, 1'b1);
    cyc();
    check("first_out_valid", out_valid, 1);
    check("first_out_pc4", out_pc4, 32'h4);
    check("first_out_data", out_data, 32'h2008_0005);
    in_valid = 1'b0;
    cyc();
    check("first_drained", out_valid, 0);

    // Streaming back-to-back with downstream always ready.
    for (int i = 0; i < 3; i++) begin
      offer(32'h4 * (i + 1), 32'h0000_1000 + i, 1'b1);
      cyc();
      check("stream_in_ready", in_ready, 1);
      check("stream_out_pc4", out_pc4, 32'h4 * (i + 1));
    end
    in_valid = 1'b0;
    cyc();
    check("stream_drained", out_valid, 0);

    // Stall fills main then skid; release drains in order.
    out_ready = 1'b0;
    offer(32'h4, 32'h0000_2000, 1'b1);
    cyc();
    check("stall_busy_in_ready", in_ready, 1);
    offer(32'h8, 32'h0000_2001, 1'b1);
    cyc();
    check("stall_full_in_ready", in_ready, 0);
    check("stall_full_out_pc4", out_pc4, 32'h4);
    in_valid = 1'b0;
    cyc();
    cyc();
    check("stall_hold_out_data", out_data, 32'h0000_2000);
    check("stall_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    cyc();
    check("drain_second_pc4", out_pc4, 32'h8);
    check("drain_in_ready_back", in_ready, 1);
    cyc();
    check("drain_empty", out_valid, 0);

    // Flush while FULL with a third entry offered: all three vanish.
    out_ready = 1'b0;
    offer(32'h4, 32'h0000_3000, 1'b0);
    cyc();
    offer(32'h8, 32'h0000_3001, 1'b0);
    cyc();
    check("flush_pre_full", in_ready, 0);
    offer(32'hC, 32'h0000_3002, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, NOP);
    check("flush_in_ready", in_ready, 1);
`ifdef PIPE_STAT_EN
    check("flush_cnt_one", flush_cnt, 1);
`endif

    // Flush while BUSY with an acceptable offer: the offer is discarded too.
    offer(32'h10, 32'h0000_3010, 1'b0);
    cyc();
    offer(32'h14, 32'h0000_3014, 1'b0);
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) cyc();
    check("flush_nothing_after", out_valid, 0);
`ifdef PIPE_STAT_EN
    check("flush_cnt_two", flush_cnt, 2);
`endif

    // Long stall: payload stable, stall counter saturates.
    out_ready = 1'b0;
    offer(32'h40, 32'h0000_4000, 1'b0);
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    check("long_stall_pc4", out_pc4, 32'h40);
    check("long_stall_data", out_data, 32'h0000_4000);
`ifdef PIPE_STAT_EN
    check("stall_cnt_sat", stall_cnt, 15);
    repeat (3) cyc();
    check("stall_cnt_sat_hold", stall_cnt, 15);
`endif

    // Async reset between edges while FULL.
    offer(32'h44, 32'h0000_4004, 1'b0);
    cyc();
    in_valid = 1'b0;
    check("pre_areset_full", in_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_in_ready", in_ready, 1);
    check("areset_out_data", out_data, NOP);
    check("areset_out_pc4", out_pc4, 0);
`ifdef PIPE_STAT_EN
    check("areset_stall_cnt", stall_cnt, 0);
    check("areset_flush_cnt", flush_cnt, 0);
`endif

    // Recovery after reset.
    cyc();
    rst = 1'b1; out_ready = 1'b1;
    offer(32'h50, 32'h0000_5000, 1'b1);
    cyc();
    check("recover_out_pc4", out_pc4, 32'h50);
    in_valid = 1'b0;
    repeat (2) cyc();
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised successor of the IF/ID inter-stage register, usable between any two pipeline stages (IF/ID, ID/EX, ...). Carries a PC+4 word and a payload word under a valid/ready handshake. A 2-entry skid buffer keeps the upstream ready signal registered. Adds a per-entry valid bit, synchronous flush (bubble insertion) and NOP substitution on empty.

Parameters:
PC_W, 32, width of PC+4 field
DATA_W, 32, width of payload (instruction) field
NOP_WORD, 32'h0000_0000, payload driven on out_data when out_valid=0 (sll $0,$0,0)
CNT_W, 16, width of statistics counters (used only with PIPE_STAT_EN)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (rst=0 resets)
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept; registered
in_pc4  input  PC_W  upstream PC+4
in_data  input  DATA_W  upstream instruction/payload
flush  input  1  synchronous kill of all held entries (branch taken / exception)
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts (0 = stall)
out_pc4  output  PC_W  held PC+4
out_data  output  DATA_W  held payload, NOP_WORD when out_valid=0
stall_cnt  output  CNT_W  (PIPE_STAT_EN only) cycles with out_valid=1 and out_ready=0
flush_cnt  output  CNT_W  (PIPE_STAT_EN only) flushes that killed at least one valid entry

Behaviour:
- Reset (rst=0, async): state EMPTY; out_valid=0; in_ready=1; out_pc4=0; out_data=NOP_WORD; skid entry invalid; counters=0.
- Accept = in_valid & in_ready. Take = out_valid & out_ready.
- Entries: main (drives outputs) and skid. in_ready = (state != FULL), taken from the state register; no combinational path from out_ready.
- States and transitions (when flush=0):
  EMPTY: accept -> BUSY, main<=in. Otherwise stay.
  BUSY: accept & take -> BUSY, main<=in. Accept & !take -> FULL, skid<=in. !accept & take -> EMPTY. Otherwise hold.
  FULL: take -> BUSY, main<=skid. Otherwise hold. No accept is possible (in_ready=0).
- Latency: accepted entry appears on out_* the next cycle if the stage was EMPTY, or if it was BUSY and main was taken in the same cycle.
- Ordering is strictly FIFO. An entry is never duplicated or dropped except by flush.
- Flush (priority over everything): next state EMPTY. main and skid are invalidated, and an entry offered in the same cycle is discarded (not accepted). A take in the flush cycle still completes downstream. The cycle after flush: out_valid=0, out_data=NOP_WORD, in_ready=1.
- While holding (stall), out_pc4/out_data are stable. While out_valid=0, out_pc4 holds its last value and out_data=NOP_WORD.
- Reset asserted mid-operation: immediate return to the reset values above, independent of clk.

Optional Feature:
PIPE_STAT_EN defined: stall_cnt increments each cycle with out_valid & !out_ready. flush_cnt increments on flush when main or skid is valid. Both saturate at all-ones, and both clear only on reset.
PIPE_STAT_EN undefined: stall_cnt/flush_cnt ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=0 with in_valid=1 -> out_valid=0, out_data=32'h0, in_ready=1. Release rst, offer pc4=0x4/data=0x20080005 -> next cycle out_valid=1, out_pc4=0x4, out_data=0x20080005.
- Streaming: out_ready=1, offer 0x4,0x8,0xC back-to-back -> out_pc4 shows 0x4,0x8,0xC on consecutive cycles; in_ready stays 1.
- Stall/skid: out_ready=0 while offering 0x4 then 0x8 -> state FULL, in_ready=0, out_pc4=0x4 held. Raise out_ready -> 0x4 then 0x8 delivered in order; in_ready returns to 1 one cycle after 0x4 is taken.
- Flush when FULL (0x4 main, 0x8 skid) with 0xC offered -> next cycle out_valid=0, out_data=NOP_WORD, in_ready=1. 0x8 and 0xC are never output. With PIPE_STAT_EN, flush_cnt=1.
- Async reset mid-stall: assert rst=0 between clock edges while FULL -> out_valid=0 and in_ready=1 immediately; stall_cnt=0.
- Saturation (PIPE_STAT_EN, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and remains 15.
